// File: rtl/z_core_mem_responder.sv
// Z-Core memory responder: word RAM behind valid/ready request/response channels with configurable wait states.
// Optional access-error checking is enabled by defining Z_CORE_MEM_ERR_EN.
module z_core_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic req_ready_nxt, rsp_valid_nxt;
  logic accept, enter_resp;

  logic             lat_we;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_wstrb;

  logic             act_we;
  logic [IDX_W-1:0] act_idx;
  logic [31:0]      act_wdata;
  logic [3:0]       act_wstrb;
  logic             act_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

`ifdef Z_CORE_MEM_ERR_EN
  logic       req_err;
  logic       lat_err;
  logic [1:0] lat_lsb;
  // Misaligned or beyond-the-array accesses are flagged instead of aliasing.
  assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= 32'(DEPTH_WORDS));
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_err <= req_err;
      lat_lsb <= req_addr[1:0];
    end
  end
  logic unused_lsb;
  assign unused_lsb = ^lat_lsb;
  assign act_err = (state == IDLE) ? req_err : lat_err;
`else
  assign act_err = 1'b0;
`endif

  // With zero wait states the memory action happens on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      act_we    = req_we;
      act_idx   = req_addr[IDX_W+1:2];
      act_wdata = req_wdata;
      act_wstrb = req_wstrb;
    end else begin
      act_we    = lat_we;
      act_idx   = lat_idx;
      act_wdata = lat_wdata;
      act_wstrb = lat_wstrb;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    req_ready_nxt = 1'b0;
    rsp_valid_nxt = 1'b0;
    accept        = 1'b0;
    enter_resp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 4'(WAIT_CYCLES);
          end else begin
            state_nxt     = RESP;
            enter_resp    = 1'b1;
            rsp_valid_nxt = 1'b1;
          end
        end else begin
          req_ready_nxt = 1'b1;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          state_nxt     = RESP;
          enter_resp    = 1'b1;
          rsp_valid_nxt = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
        end else begin
          rsp_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      if (enter_resp) begin
        rsp_rdata <= (act_we || act_err) ? 32'd0 : mem[act_idx];
        rsp_err   <= act_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_idx   <= req_addr[IDX_W+1:2];
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // A write that is dropped by reset while waiting never reaches the array.
  always_ff @(posedge clk) begin
    if (enter_resp && act_we && !act_err) begin
      for (int b = 0; b < 4; b++) begin
        if (act_wstrb[b]) mem[act_idx][8*b +: 8] <= act_wdata[8*b +: 8];
      end
    end
  end

endmodule
